// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU write-back trace checker.
// States, ASCII tokens, output encodings and error bit positions.
package cpu_trace_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TIME,
        S_PC,
        S_COLON,
        S_SP1,
        S_REG,
        S_ADDR,
        S_SP2,
        S_EQ,
        S_SP3,
        S_DATA,
        S_HASH,
        S_DONE
    } state_t;

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    localparam logic [1:0] FMT_NONE = 2'b00;
    localparam logic [1:0] FMT_REG  = 2'b01;
    localparam logic [1:0] FMT_MEM  = 2'b10;

    localparam int ERR_PC   = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_REG  = 2;

    // reg field saturates here so any over-range value still flags as > 31
    localparam logic [5:0] REG_SAT = 6'd32;

endpackage

// File: rtl/cpu_trace_checker_if.sv
// Character-in / result-out bundle between the trace char source and the checker.
// The checker uses the slave modport; the char source / scoreboard side uses master.
interface cpu_trace_checker_if #(
    parameter int HEX_DIGITS = 8
);
    logic [7:0]              char;
    logic [1:0]              format_type;
    logic [2:0]              error_code;
    logic [4*HEX_DIGITS-1:0] line_data;

    modport master (
        output char,
        input  format_type,
        input  error_code,
        input  line_data
    );

    modport slave (
        input  char,
        output format_type,
        output error_code,
        output line_data
    );
endinterface

// File: rtl/trace_char_class.sv
// Purpose: classify one ASCII char as decimal / hex digit and give its nibble value.
// Latency: purely combinational.
// Backpressure: none.
module trace_char_class #(
    parameter int ALLOW_UPPER = 0
) (
    input  logic [7:0] char_in,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] nibble
);
    logic is_lower;
    logic is_upper;

    always_comb begin
        is_dec   = (char_in >= 8'h30) && (char_in <= 8'h39);
        is_lower = (char_in >= 8'h61) && (char_in <= 8'h66);
        is_upper = (ALLOW_UPPER != 0) && (char_in >= 8'h41) && (char_in <= 8'h46);
        is_hex   = is_dec || is_lower || is_upper;
        nibble   = 4'h0;
        if (is_dec) begin
            nibble = char_in[3:0];
        end else if (is_lower || is_upper) begin
            // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
            nibble = char_in[3:0] + 4'd9;
        end
    end
endmodule

// File: rtl/cpu_trace_checker.sv
// Purpose: streaming syntax + range checker for register/memory write-back trace lines.
// Latency: result valid for exactly one cycle, the cycle after the terminating '#'.
// Backpressure: none; one char is consumed every cycle.
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter int          TIME_DIGITS = 4,
    parameter int          REG_DIGITS  = 4,
    parameter int          HEX_DIGITS  = 8,
    parameter logic [31:0] PC_MIN      = 32'h0000_3000,
    parameter logic [31:0] PC_MAX      = 32'h0000_6ffc,
    parameter logic [31:0] ADDR_MAX    = 32'h0000_2ffc,
    parameter int          ALLOW_UPPER = 0
) (
    input  logic             clk,
    input  logic             reset,
    cpu_trace_checker_if.slave trc
);
    localparam int DW = 4 * HEX_DIGITS;
    localparam int TW = $clog2(TIME_DIGITS + 1);
    localparam int RW = $clog2(REG_DIGITS + 1);
    localparam int HW = $clog2(HEX_DIGITS + 1);

    localparam logic [DW-1:0] PC_LO   = DW'(PC_MIN);
    localparam logic [DW-1:0] PC_HI   = DW'(PC_MAX);
    localparam logic [DW-1:0] ADDR_HI = DW'(ADDR_MAX);

    state_t        state_q, state_d;
    logic [TW-1:0] time_cnt_q, time_cnt_d;
    logic [RW-1:0] reg_cnt_q, reg_cnt_d;
    logic [HW-1:0] hex_cnt_q, hex_cnt_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [5:0]    reg_q, reg_d;
    logic [1:0]    type_q, type_d;
    logic [2:0]    err_q, err_d;
    logic [DW-1:0] line_data_q, line_data_d;

    logic       is_dec;
    logic       is_hex;
    logic [3:0] nibble;
    logic [9:0] reg_acc;

    trace_char_class #(
        .ALLOW_UPPER(ALLOW_UPPER)
    ) u_class (
        .char_in(trc.char),
        .is_dec (is_dec),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    always_comb begin
        state_d     = state_q;
        time_cnt_d  = time_cnt_q;
        reg_cnt_d   = reg_cnt_q;
        hex_cnt_d   = hex_cnt_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        data_d      = data_q;
        reg_d       = reg_q;
        type_d      = type_q;
        err_d       = err_q;
        line_data_d = line_data_q;
        reg_acc     = 10'(reg_q) * 10'd10 + 10'(nibble);

        if (trc.char == CH_CARET) begin
            state_d    = S_TIME;
            time_cnt_d = '0;
            reg_cnt_d  = '0;
            hex_cnt_d  = '0;
            pc_d       = '0;
            addr_d     = '0;
            data_d     = '0;
            reg_d      = '0;
        end else begin
            // any char not accepted below breaks the grammar and drops the line
            state_d = S_IDLE;
            case (state_q)
                S_TIME: begin
                    if (is_dec && (time_cnt_q != TW'(TIME_DIGITS))) begin
                        state_d    = S_TIME;
                        time_cnt_d = time_cnt_q + TW'(1);
                    end else if ((trc.char == CH_AT) && (time_cnt_q != '0)) begin
                        state_d = S_PC;
                    end
                end
                S_PC: begin
                    if (is_hex) begin
                        pc_d = (pc_q << 4) | DW'(nibble);
                        if (hex_cnt_q == HW'(HEX_DIGITS - 1)) begin
                            state_d   = S_COLON;
                            hex_cnt_d = '0;
                        end else begin
                            state_d   = S_PC;
                            hex_cnt_d = hex_cnt_q + HW'(1);
                        end
                    end
                end
                S_COLON: begin
                    if (trc.char == CH_COLON) state_d = S_SP1;
                end
                S_SP1: begin
                    if (trc.char == CH_SPACE) begin
                        state_d = S_SP1;
                    end else if (trc.char == CH_DOLLAR) begin
                        state_d   = S_REG;
                        type_d    = FMT_REG;
                        reg_cnt_d = '0;
                        reg_d     = '0;
                    end else if (trc.char == CH_STAR) begin
                        state_d   = S_ADDR;
                        type_d    = FMT_MEM;
                        hex_cnt_d = '0;
                    end
                end
                S_REG: begin
                    if (is_dec && (reg_cnt_q != RW'(REG_DIGITS))) begin
                        state_d   = S_REG;
                        reg_cnt_d = reg_cnt_q + RW'(1);
                        reg_d     = (reg_acc > 10'(REG_SAT)) ? REG_SAT : reg_acc[5:0];
                    end else if ((trc.char == CH_SPACE) && (reg_cnt_q != '0)) begin
                        state_d = S_SP2;
                    end else if ((trc.char == CH_LT) && (reg_cnt_q != '0)) begin
                        state_d = S_EQ;
                    end
                end
                S_ADDR: begin
                    if (is_hex) begin
                        addr_d = (addr_q << 4) | DW'(nibble);
                        if (hex_cnt_q == HW'(HEX_DIGITS - 1)) begin
                            state_d   = S_SP2;
                            hex_cnt_d = '0;
                        end else begin
                            state_d   = S_ADDR;
                            hex_cnt_d = hex_cnt_q + HW'(1);
                        end
                    end
                end
                S_SP2: begin
                    if (trc.char == CH_SPACE) state_d = S_SP2;
                    else if (trc.char == CH_LT) state_d = S_EQ;
                end
                S_EQ: begin
                    if (trc.char == CH_EQ) state_d = S_SP3;
                end
                S_SP3: begin
                    if (trc.char == CH_SPACE) begin
                        state_d = S_SP3;
                    end else if (is_hex) begin
                        data_d    = (data_q << 4) | DW'(nibble);
                        hex_cnt_d = HW'(1);
                        state_d   = (HEX_DIGITS == 1) ? S_HASH : S_DATA;
                    end
                end
                S_DATA: begin
                    if (is_hex) begin
                        data_d = (data_q << 4) | DW'(nibble);
                        if (hex_cnt_q == HW'(HEX_DIGITS - 1)) begin
                            state_d   = S_HASH;
                            hex_cnt_d = '0;
                        end else begin
                            state_d   = S_DATA;
                            hex_cnt_d = hex_cnt_q + HW'(1);
                        end
                    end
                end
                S_HASH: begin
                    if (trc.char == CH_HASH) begin
                        state_d          = S_DONE;
                        line_data_d      = data_q;
                        err_d[ERR_PC]    = (pc_q < PC_LO) || (pc_q > PC_HI) || (pc_q[1:0] != 2'b00);
                        err_d[ERR_ADDR]  = (type_q == FMT_MEM) &&
                                           ((addr_q > ADDR_HI) || (addr_q[1:0] != 2'b00));
                        err_d[ERR_REG]   = (type_q == FMT_REG) && (reg_q > 6'd31);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            time_cnt_q  <= '0;
            reg_cnt_q   <= '0;
            hex_cnt_q   <= '0;
            pc_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            reg_q       <= '0;
            type_q      <= FMT_NONE;
            err_q       <= '0;
            line_data_q <= '0;
        end else begin
            state_q     <= state_d;
            time_cnt_q  <= time_cnt_d;
            reg_cnt_q   <= reg_cnt_d;
            hex_cnt_q   <= hex_cnt_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            reg_q       <= reg_d;
            type_q      <= type_d;
            err_q       <= err_d;
            line_data_q <= line_data_d;
        end
    end

    // type_q cannot change between '#' and DONE, so it doubles as the format output
    assign trc.format_type = (state_q == S_DONE) ? type_q : FMT_NONE;
    assign trc.error_code  = (state_q == S_DONE) ? err_q : 3'b000;
    assign trc.line_data   = line_data_q;

endmodule
